// File: rtl/bram_bank_arbiter.sv
// bram_bank_arbiter
//   Routes NUM_REQ requesters onto NUM_BANKS BRAM bank controllers. Each bank
//   owns an IDLE/BUSY grant FSM and picks a winner by fixed priority (lowest
//   index) or round-robin (search from pointer+1). A bank keeps one read in
//   flight; the read's requester id travels with a countdown and is used to
//   steer the returning bank_do word onto the shared response bus. When
//   several banks return together, the lowest bank is forwarded and the others
//   wait in a one-entry skid register per bank.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-low reset
//   rr_mode                  1 = round-robin, 0 = fixed priority
//   req_valid/we/addr/wdata  per-requester command (addr/wdata flattened)
//   req_ready                command accepted this cycle
//   rsp_valid, rsp_data      per-requester read-data strobe, shared data bus
//   bank_in_valid/wr/addr/di registered per-bank command
//   bank_do                  per-bank read data, READ_LAT after the command
module bram_bank_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 10,
  parameter int BANK_LSB  = 12
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rr_mode,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [NUM_BANKS-1:0]          bank_in_valid,
  output logic [NUM_BANKS-1:0]          bank_wr,
  output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   bank_di,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_do
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LAT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} bank_state_t;

  bank_state_t                 state_r     [NUM_BANKS];
  bank_state_t                 state_nxt_s [NUM_BANKS];
  logic [CW-1:0]               cnt_r       [NUM_BANKS];
  logic [IW-1:0]               tag_r       [NUM_BANKS];
  logic [IW-1:0]               ptr_r       [NUM_BANKS];
  logic [DATA_W-1:0]           skid_data_r [NUM_BANKS];
  logic [IW-1:0]               skid_id_r   [NUM_BANKS];
  logic [NUM_BANKS-1:0]        ret_valid_r;
  logic [NUM_BANKS-1:0]        skid_valid_r;
  logic [NUM_BANKS-1:0]        bank_in_valid_r;
  logic [NUM_BANKS-1:0]        bank_wr_r;
  logic [NUM_BANKS*ADDR_W-1:0] bank_addr_r;
  logic [NUM_BANKS*DATA_W-1:0] bank_di_r;

  logic [BW-1:0]               req_bank_s  [NUM_REQ];
  logic [NUM_REQ-1:0]          cand_s      [NUM_BANKS];
  logic [IW-1:0]               gnt_idx_s   [NUM_BANKS];
  logic [NUM_BANKS-1:0]        gnt_found_s;
  logic [NUM_BANKS-1:0]        load_read_s;
  logic [NUM_BANKS-1:0]        read_block_s;
  logic [NUM_BANKS-1:0]        rsp_win_s;
  logic                        rsp_found_s;
  logic [IW-1:0]               rsp_id_s;
  logic [DATA_W-1:0]           rsp_data_s;
  logic [NUM_REQ-1:0]          ready_s;
  logic [NUM_REQ-1:0]          rsp_valid_s;

  // First set bit of vec, scanning circularly upward from index start.
  function automatic logic [IW:0] first_set(input logic [NUM_REQ-1:0] vec, input int start);
    logic          hit;
    logic [IW-1:0] pos;
    int            idx;
    hit = 1'b0;
    pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (start + k) % NUM_REQ;
      if (!hit && vec[idx]) begin
        hit = 1'b1;
        pos = IW'(idx);
      end
    end
    return {hit, pos};
  endfunction

  // Bank-select field of each requester address.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (NUM_BANKS > 1) begin
        req_bank_s[i] = req_addr[i*ADDR_W + BANK_LSB +: BW];
      end else begin
        req_bank_s[i] = '0;
      end
    end
  end

  // Response bus: lowest bank with live return or skid entry is forwarded.
  always_comb begin
    rsp_found_s = 1'b0;
    rsp_id_s    = '0;
    rsp_data_s  = '0;
    rsp_win_s   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!rsp_found_s && (ret_valid_r[b] || skid_valid_r[b])) begin
        rsp_found_s  = 1'b1;
        rsp_win_s[b] = 1'b1;
        // A bank never has a skid entry and a live return at the same time.
        rsp_id_s   = skid_valid_r[b] ? skid_id_r[b] : tag_r[b];
        rsp_data_s = skid_valid_r[b] ? skid_data_r[b] : bank_do[b*DATA_W +: DATA_W];
      end else begin
        rsp_win_s[b] = 1'b0;
      end
    end
    // A losing return lands in the skid this edge, so it already blocks reads.
    read_block_s = skid_valid_r | (ret_valid_r & ~rsp_win_s);
  end

  // Per-bank candidate masks and winner selection.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_s[b][i] = req_valid[i] && (req_bank_s[i] == BW'(b)) && (state_r[b] == ST_IDLE)
                       && (req_we[i] || !read_block_s[b]);
      end
      {gnt_found_s[b], gnt_idx_s[b]} = first_set(cand_s[b], rr_mode ? (int'(ptr_r[b]) + 1) : 0);
      load_read_s[b] = gnt_found_s[b] && !req_we[gnt_idx_s[b]];
    end
  end

  // Bank FSM next state: a granted read parks the bank until its data is due.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_nxt_s[b] = state_r[b];
      case (state_r[b])
        ST_IDLE: state_nxt_s[b] = load_read_s[b] ? ST_BUSY : ST_IDLE;
        ST_BUSY: state_nxt_s[b] = (cnt_r[b] == '0) ? ST_IDLE : ST_BUSY;
        default: state_nxt_s[b] = ST_IDLE;
      endcase
    end
  end

  // Requester-facing strobes; ready is forced low while reset is held.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_s[i] = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        ready_s[i] = ready_s[i] | (gnt_found_s[b] && (gnt_idx_s[b] == IW'(i)));
      end
      rsp_valid_s[i] = rsp_found_s && (rsp_id_s == IW'(i));
    end
  end

  // Bank FSM state, read countdown, tag and return strobe.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_r[b] <= ST_IDLE;
        cnt_r[b]   <= '0;
        tag_r[b]   <= '0;
      end
      ret_valid_r <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_r[b]     <= state_nxt_s[b];
        ret_valid_r[b] <= (state_r[b] == ST_BUSY) && (cnt_r[b] == '0);
        if (load_read_s[b]) begin
          cnt_r[b] <= CNT_LOAD;
          tag_r[b] <= gnt_idx_s[b];
        end else if (cnt_r[b] != '0) begin
          cnt_r[b] <= cnt_r[b] - CNT_ONE;
        end else begin
          cnt_r[b] <= cnt_r[b];
        end
      end
    end
  end

  // Registered bank command and round-robin pointer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_r[b] <= '0;
      end
      bank_in_valid_r <= '0;
      bank_wr_r       <= '0;
      bank_addr_r     <= '0;
      bank_di_r       <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_in_valid_r[b] <= gnt_found_s[b];
        if (gnt_found_s[b]) begin
          ptr_r[b]                          <= gnt_idx_s[b];
          bank_wr_r[b]                      <= req_we[gnt_idx_s[b]];
          bank_addr_r[b*ADDR_W +: ADDR_W]   <= req_addr[gnt_idx_s[b]*ADDR_W +: ADDR_W];
          bank_di_r[b*DATA_W +: DATA_W]     <= req_wdata[gnt_idx_s[b]*DATA_W +: DATA_W];
        end else begin
          bank_wr_r[b] <= 1'b0;
        end
      end
    end
  end

  // Skid entries: capture a losing return, release once forwarded.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        skid_data_r[b] <= '0;
        skid_id_r[b]   <= '0;
      end
      skid_valid_r <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (ret_valid_r[b] && !rsp_win_s[b]) begin
          skid_valid_r[b] <= 1'b1;
          skid_data_r[b]  <= bank_do[b*DATA_W +: DATA_W];
          skid_id_r[b]    <= tag_r[b];
        end else if (skid_valid_r[b] && rsp_win_s[b]) begin
          skid_valid_r[b] <= 1'b0;
        end else begin
          skid_valid_r[b] <= skid_valid_r[b];
        end
      end
    end
  end

  assign req_ready     = ready_s & {NUM_REQ{wb_rst_i}};
  assign rsp_valid     = rsp_valid_s;
  assign rsp_data      = rsp_data_s;
  assign bank_in_valid = bank_in_valid_r;
  assign bank_wr       = bank_wr_r;
  assign bank_addr     = bank_addr_r;
  assign bank_di       = bank_di_r;

endmodule

// File: tb/tb_bram_bank_arbiter.sv
// Directed self-checking bench for bram_bank_arbiter. A behavioural BRAM
// model returns 0xC0DE_0000 | addr exactly READ_LAT cycles after each read
// command and a distinct junk word in every other cycle.
module tb_bram_bank_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int NUM_BANKS = 2;
  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int READ_LAT  = 10;
  localparam int BANK_LSB  = 12;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        rr_mode;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_we;
  logic [NUM_REQ*ADDR_W-1:0]   req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_wdata;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]           rsp_data;
  logic [NUM_BANKS-1:0]        bank_in_valid;
  logic [NUM_BANKS-1:0]        bank_wr;
  logic [NUM_BANKS*ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS*DATA_W-1:0] bank_di;
  logic [NUM_BANKS*DATA_W-1:0] bank_do;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bram_bank_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .READ_LAT(READ_LAT), .BANK_LSB(BANK_LSB)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .rr_mode(rr_mode),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bank_in_valid(bank_in_valid), .bank_wr(bank_wr), .bank_addr(bank_addr),
    .bank_di(bank_di), .bank_do(bank_do)
  );

  // BRAM model: read command delay line per bank
  logic [ADDR_W-1:0] mdl_addr [NUM_BANKS][READ_LAT];
  logic              mdl_rd   [NUM_BANKS][READ_LAT];

  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      mdl_rd[b][0]   <= bank_in_valid[b] & ~bank_wr[b];
      mdl_addr[b][0] <= bank_addr[b*ADDR_W +: ADDR_W];
      for (int k = 1; k < READ_LAT; k++) begin
        mdl_rd[b][k]   <= mdl_rd[b][k-1];
        mdl_addr[b][k] <= mdl_addr[b][k-1];
      end
    end
  end

  always_comb begin
    bank_do = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_do[b*DATA_W +: DATA_W] = mdl_rd[b][READ_LAT-1]
        ? (32'hC0DE_0000 | {19'h0, mdl_addr[b][READ_LAT-1]})
        : (32'hBAD0_0000 + 32'(b));
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_valid[i]                  = v;
    req_we[i]                     = we;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    rr_mode   = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a cycle with any req_ready; returns the granted index.
  task automatic wait_grant(input int max_cyc, output int idx);
    idx = -1;
    for (int c = 0; c < max_cyc && idx < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) idx = i;
      end
      next_cycle();
    end
    if (idx < 0) check_val("grant_timeout", 64'd0, 64'd1);
  endtask

  int   idx;
  logic any_rsp;

  initial begin
    rst_n = 1'b0; rr_mode = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    #2;
    check_val("rst_bank_in_valid", bank_in_valid, 0);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_data", rsp_data, 0);
    check_val("rst_bank_addr", bank_addr, 0);
    do_reset();

    // 1: single read, fixed mode
    set_req(0, 1'b1, 1'b0, 13'h005, 32'h0);
    @(negedge clk); check_val("t1_ready", req_ready, 4'b0001);
    next_cycle(); req_valid = '0;
    @(negedge clk);
    check_val("t1_bank_valid", bank_in_valid, 2'b01);
    check_val("t1_bank_wr", bank_wr, 2'b00);
    check_val("t1_bank_addr", bank_addr[0 +: ADDR_W], 13'h005);
    for (int c = 2; c <= 10; c++) begin
      next_cycle(); @(negedge clk);
      check_val("t1_rsp_early", rsp_valid, 4'b0000);
    end
    next_cycle(); @(negedge clk);
    check_val("t1_rsp_valid", rsp_valid, 4'b0001);
    check_val("t1_rsp_data", rsp_data, 32'hC0DE_0005);
    next_cycle(); @(negedge clk);
    check_val("t1_rsp_once", rsp_valid, 4'b0000);

    // 2: contention, fixed then round-robin (pointer sits on 0 after fixed grants)
    do_reset();
    set_req(0, 1'b1, 1'b0, 13'h001, 32'h0);
    set_req(2, 1'b1, 1'b0, 13'h002, 32'h0);
    for (int g = 0; g < 3; g++) begin
      wait_grant(READ_LAT + 3, idx);
      check_val("t2_fixed_grant", idx, 0);
    end
    rr_mode = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_grant(READ_LAT + 3, idx);
      check_val("t2_rr_grant", idx, (g % 2 == 0) ? 2 : 0);
    end

    // 3: bank parallelism and skid serialisation
    do_reset();
    set_req(1, 1'b1, 1'b0, 13'h0010, 32'h0);
    set_req(3, 1'b1, 1'b0, 13'h1010, 32'h0);
    @(negedge clk); check_val("t3_ready", req_ready, 4'b1010);
    next_cycle(); req_valid = '0;
    @(negedge clk);
    check_val("t3_bank_valid", bank_in_valid, 2'b11);
    check_val("t3_addr0", bank_addr[0 +: ADDR_W], 13'h0010);
    check_val("t3_addr1", bank_addr[ADDR_W +: ADDR_W], 13'h1010);
    repeat (10) next_cycle();
    @(negedge clk);
    check_val("t3_rsp1_valid", rsp_valid, 4'b0010);
    check_val("t3_rsp1_data", rsp_data, 32'hC0DE_0010);
    next_cycle(); @(negedge clk);
    check_val("t3_rsp3_valid", rsp_valid, 4'b1000);
    check_val("t3_rsp3_data", rsp_data, 32'hC0DE_1010);
    next_cycle(); @(negedge clk);
    check_val("t3_rsp_done", rsp_valid, 4'b0000);

    // 4: eight back-to-back writes to bank 1
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) set_req(2, 1'b1, 1'b1, 13'h1000 + 13'(k), 32'h5A00_0000 + 32'(k));
      else req_valid = '0;
      @(negedge clk);
      if (k < 8) check_val("t4_ready", req_ready, 4'b0100);
      if (k > 0) begin
        check_val("t4_bank_valid", bank_in_valid, 2'b10);
        check_val("t4_bank_wr", bank_wr, 2'b10);
        check_val("t4_bank_addr", bank_addr[ADDR_W +: ADDR_W], 13'h1000 + 13'(k - 1));
        check_val("t4_bank_di", bank_di[DATA_W +: DATA_W], 32'h5A00_0000 + 32'(k - 1));
      end
      next_cycle();
    end
    @(negedge clk); check_val("t4_stop", bank_in_valid, 2'b00);
    any_rsp = 1'b0;
    for (int c = 0; c < 13; c++) begin
      next_cycle(); @(negedge clk);
      if (rsp_valid != 4'b0000) any_rsp = 1'b1;
    end
    check_val("t4_no_rsp", any_rsp, 1'b0);
    next_cycle();

    // 5: reset in the middle of a read
    do_reset();
    rr_mode = 1'b1;
    set_req(2, 1'b1, 1'b0, 13'h003, 32'h0);
    @(negedge clk); check_val("t5_rd_ready", req_ready, 4'b0100);
    next_cycle(); req_valid = '0;
    next_cycle();
    next_cycle();
    set_req(1, 1'b1, 1'b1, 13'h1007, 32'h1234_5678);
    @(negedge clk); check_val("t5_wr_ready", req_ready, 4'b0010);
    next_cycle(); req_valid = '0;
    check_val("t5_pre_wr", bank_in_valid, 2'b10);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_bank_valid", bank_in_valid, 2'b00);
    check_val("t5_rst_bank_wr", bank_wr, 2'b00);
    check_val("t5_rst_bank_addr", bank_addr, 0);
    check_val("t5_rst_bank_di", bank_di, 0);
    set_req(0, 1'b1, 1'b0, 13'h004, 32'h0);
    set_req(1, 1'b1, 1'b0, 13'h005, 32'h0);
    set_req(3, 1'b1, 1'b0, 13'h006, 32'h0);
    #1;
    check_val("t5_rst_ready", req_ready, 4'b0000);
    check_val("t5_rst_rsp", rsp_valid, 4'b0000);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk); check_val("t5_first_grant", req_ready, 4'b0010);
    next_cycle(); req_valid = '0;
    any_rsp = 1'b0;
    for (int c = 7; c <= 16; c++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0000) any_rsp = 1'b1;
      next_cycle();
    end
    check_val("t5_no_stale_rsp", any_rsp, 1'b0);
    @(negedge clk);
    check_val("t5_new_rsp_valid", rsp_valid, 4'b0010);
    check_val("t5_new_rsp_data", rsp_data, 32'hC0DE_0005);
    next_cycle();

    // 6: round-robin fairness, all requesters on bank 0
    do_reset();
    rr_mode = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, 13'h020 + 13'(i), 32'h0);
    for (int g = 0; g < 5; g++) begin
      wait_grant(4 * READ_LAT, idx);
      check_val("t6_rr_grant", idx, (g + 1) % 4);
    end
    req_valid = '0;
    repeat (2) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
